// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control core: FSM state encoding,
// reset/stall polarity constants and performance counter width.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pipe_state_t;

    localparam logic RESET_ACTIVE = 1'b1;
    localparam logic STALL_HOLD   = 1'b1;

    localparam int unsigned PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller.
// Turns per-stage stall requests into a thermometer hold vector (a stalled
// stage also holds every younger stage below it), issues a one-cycle flush
// pulse with a registered redirect PC, and watches for stalls that never end.
// Optional feature macro PIPE_CTRL_PERF_EN adds stall_cnt / flush_cnt
// performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 6,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MAX_STALL  = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  flush_req,
    input  logic [ADDR_W-1:0]     flush_pc,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  flush,
    output logic [ADDR_W-1:0]     new_pc,
    output logic                  stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    localparam int unsigned      CNT_W   = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

    pipe_state_t      state;
    logic [CNT_W-1:0] stall_run;
    logic [CNT_W-1:0] stall_run_nxt;
    logic             stall_any;
    logic             take_flush;

    // Highest requesting stage and everything below it are held.
    function automatic logic [NUM_STAGES-1:0] stall_decode(input logic [NUM_STAGES-1:0] req);
        logic [NUM_STAGES-1:0] hold;
        logic                  seen;
        hold = '0;
        seen = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (req[i] == STALL_HOLD) begin
                seen = 1'b1;
            end
            hold[i] = seen;
        end
        return hold;
    endfunction

    // Hold vector follows requests in RUN; forced clear in FLUSH and reset.
    always_comb begin
        stall = '0;
        if ((reset != RESET_ACTIVE) && (state == RUN)) begin
            stall = stall_decode(stall_req);
        end
    end

    // Saturating next value of the consecutive-stall counter and flush accept.
    always_comb begin
        stall_any     = |stall;
        take_flush    = (state == RUN) && flush_req;
        stall_run_nxt = '0;
        if (stall_any) begin
            stall_run_nxt = (stall_run == CNT_MAX) ? stall_run : stall_run + CNT_W'(1);
        end
    end

    // RUN/FLUSH state machine, redirect capture and stall watchdog.
    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) begin
            state         <= RUN;
            flush         <= 1'b0;
            new_pc        <= '0;
            stall_run     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            stall_run <= stall_run_nxt;
            if (stall_run_nxt == CNT_MAX) begin
                stall_timeout <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (take_flush) begin
                        state  <= FLUSH;
                        flush  <= 1'b1;
                        new_pc <= flush_pc;
                    end else begin
                        flush  <= 1'b0;
                    end
                end
                FLUSH: begin
                    state <= RUN;
                    flush <= 1'b0;
                end
                default: begin
                    state <= RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Free-running, wrapping counts of stalled cycles and issued flushes.
    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_any) begin
                stall_cnt <= stall_cnt + PERF_CNT_W'(1);
            end
            if (take_flush) begin
                flush_cnt <= flush_cnt + PERF_CNT_W'(1);
            end
        end
    end
`endif

endmodule
